// File: rtl/store_commit_buffer_pkg.sv
// Shared types for the post-retirement store commit buffer: entry layout,
// word/byte geometry and the byte-merge helper used when coalescing.
package store_commit_buffer_pkg;

  localparam int ADDR_W           = 32;
  localparam int DATA_W           = 32;
  localparam int MASK_W           = DATA_W / 8;
  localparam int WORD_W           = ADDR_W - 2;
  localparam int SB_DEPTH_DEFAULT = 4;

  typedef logic [$clog2(SB_DEPTH_DEFAULT):0] sb_pointer_t;

  typedef struct packed {
    logic [WORD_W-1:0] word_addr;
    logic [DATA_W-1:0] data;
    logic [MASK_W-1:0] byte_mask;
  } sb_entry_t;

  // Newer bytes overwrite older ones lane by lane; the mask accumulates.
  function automatic sb_entry_t sb_merge(input sb_entry_t old_entry,
                                         input logic [DATA_W-1:0] data,
                                         input logic [MASK_W-1:0] mask);
    sb_entry_t merged;
    merged = old_entry;
    for (int b = 0; b < MASK_W; b++) begin
      if (mask[b]) merged.data[8*b +: 8] = data[8*b +: 8];
    end
    merged.byte_mask = old_entry.byte_mask | mask;
    return merged;
  endfunction

endpackage

// File: rtl/store_commit_buffer_forward_sel.sv
// Per-lane youngest-match selector: rotates matches so the head is bit 0,
// picks the highest set bit (youngest) and rotates the grant back.
module sb_forward_sel
  import store_commit_buffer_pkg::*;
#(
  parameter int SB_DEPTH    = SB_DEPTH_DEFAULT,
  parameter int SB_IDX_BITS = $clog2(SB_DEPTH)
) (
  input  logic [SB_DEPTH-1:0]    match,
  input  logic [SB_IDX_BITS-1:0] head_idx,
  output logic [SB_DEPTH-1:0]    grant
);

  logic [SB_DEPTH-1:0]    rot_match;
  logic [SB_DEPTH-1:0]    rot_grant;
  logic [SB_IDX_BITS-1:0] phys;

  function automatic logic [SB_DEPTH-1:0] psel_youngest(input logic [SB_DEPTH-1:0] req);
    logic [SB_DEPTH-1:0] gnt;
    gnt = '0;
    for (int j = 0; j < SB_DEPTH; j++) begin
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
      end
    end
    return gnt;
  endfunction

  always_comb begin
    rot_match = '0;
    grant     = '0;
    phys      = '0;
    for (int j = 0; j < SB_DEPTH; j++) begin
      phys         = SB_IDX_BITS'(j) + head_idx;
      rot_match[j] = match[phys];
    end
    rot_grant = psel_youngest(rot_match);
    for (int j = 0; j < SB_DEPTH; j++) begin
      phys        = SB_IDX_BITS'(j) + head_idx;
      grant[phys] = rot_grant[j];
    end
  end

endmodule

// File: rtl/store_commit_buffer.sv
// Post-retirement store buffer: in-order drain to the D-cache plus byte-granular
// load forwarding. Same-word coalescing is enabled by defining STORE_COALESCE_EN.
module store_commit_buffer
  import store_commit_buffer_pkg::*;
#(
  parameter int SB_DEPTH    = SB_DEPTH_DEFAULT,
  parameter int SB_IDX_BITS = $clog2(SB_DEPTH)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 store_req_valid,
  input  logic [31:0]          store_req_addr,
  input  logic [31:0]          store_req_data,
  input  logic [3:0]           store_req_byte_mask,
  output logic                 store_req_accepted,
  output logic                 dcache_wr_valid,
  output logic [31:0]          dcache_wr_addr,
  output logic [31:0]          dcache_wr_data,
  output logic [3:0]           dcache_wr_byte_mask,
  input  logic                 dcache_wr_ready,
  input  logic [31:0]          sb_load_addr,
  output logic [31:0]          sb_load_data,
  output logic [3:0]           sb_load_mask,
  output logic [SB_IDX_BITS:0] sb_count,
  output logic                 sb_empty
);

  localparam logic [SB_IDX_BITS:0] PTR_ONE = 1;

  sb_entry_t entries [SB_DEPTH];

  logic [SB_IDX_BITS:0]   head, tail, count;
  logic [SB_IDX_BITS-1:0] head_idx, tail_idx, rel;
  logic                   full, empty, coalesce_hit, push_new, pop;
  logic [WORD_W-1:0]      req_word, load_word;
  sb_entry_t              new_entry;
  logic [SB_DEPTH-1:0]    entry_valid;
  logic [SB_DEPTH-1:0]    lane_match [MASK_W];
  logic [SB_DEPTH-1:0]    lane_grant [MASK_W];
  logic                   unused_addr_bits;

  assign req_word         = store_req_addr[31:2];
  assign load_word        = sb_load_addr[31:2];
  assign unused_addr_bits = ^{store_req_addr[1:0], sb_load_addr[1:0]};

  assign head_idx = head[SB_IDX_BITS-1:0];
  assign tail_idx = tail[SB_IDX_BITS-1:0];
  assign count    = tail - head;
  assign empty    = (head == tail);
  assign full     = (head_idx == tail_idx) && (head[SB_IDX_BITS] != tail[SB_IDX_BITS]);

`ifdef STORE_COALESCE_EN
  logic [SB_IDX_BITS:0]   tail_m1;
  logic [SB_IDX_BITS-1:0] last_idx;
  assign tail_m1  = tail - PTR_ONE;
  assign last_idx = tail_m1[SB_IDX_BITS-1:0];
  // The head is never merged into: it may be on the D-cache bus right now.
  assign coalesce_hit = store_req_valid && !empty &&
                        (entries[last_idx].word_addr == req_word) && (tail_m1 != head);
`else
  assign coalesce_hit = 1'b0;
`endif

  // A same-cycle pop does not free space for a push.
  assign push_new           = store_req_valid && !full && !coalesce_hit;
  assign store_req_accepted = push_new || coalesce_hit;

  assign dcache_wr_valid     = !empty;
  assign dcache_wr_addr      = {entries[head_idx].word_addr, 2'b00};
  assign dcache_wr_data      = entries[head_idx].data;
  assign dcache_wr_byte_mask = entries[head_idx].byte_mask;
  assign pop                 = dcache_wr_valid && dcache_wr_ready;

  assign sb_count = count;
  assign sb_empty = empty;

  always_comb begin
    new_entry.word_addr = req_word;
    new_entry.data      = store_req_data;
    new_entry.byte_mask = store_req_byte_mask;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      for (int i = 0; i < SB_DEPTH; i++) entries[i] <= '0;
    end else begin
      if (pop) head <= head + PTR_ONE;
      if (push_new) begin
        entries[tail_idx] <= new_entry;
        tail              <= tail + PTR_ONE;
      end
`ifdef STORE_COALESCE_EN
      else if (coalesce_hit) begin
        entries[last_idx] <= sb_merge(entries[last_idx], store_req_data, store_req_byte_mask);
      end
`endif
    end
  end

  // Entry i is live when its distance from head is below the occupancy.
  always_comb begin
    rel         = '0;
    entry_valid = '0;
    for (int b = 0; b < MASK_W; b++) lane_match[b] = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      rel            = SB_IDX_BITS'(i) - head_idx;
      entry_valid[i] = ({1'b0, rel} < count);
      for (int b = 0; b < MASK_W; b++) begin
        lane_match[b][i] = entry_valid[i] && (entries[i].word_addr == load_word) &&
                           entries[i].byte_mask[b];
      end
    end
  end

  for (genvar b = 0; b < MASK_W; b++) begin : g_lane
    sb_forward_sel #(
      .SB_DEPTH    (SB_DEPTH),
      .SB_IDX_BITS (SB_IDX_BITS)
    ) u_sel (
      .match    (lane_match[b]),
      .head_idx (head_idx),
      .grant    (lane_grant[b])
    );
  end

  always_comb begin
    sb_load_data = '0;
    sb_load_mask = '0;
    for (int b = 0; b < MASK_W; b++) begin
      for (int i = 0; i < SB_DEPTH; i++) begin
        if (lane_grant[b][i]) begin
          sb_load_data[8*b +: 8] = entries[i].data[8*b +: 8];
          sb_load_mask[b]        = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_store_commit_buffer.sv
// Directed bench for store_commit_buffer; covers coalescing when STORE_COALESCE_EN is defined.
module tb_store_commit_buffer;

  logic        clock = 1'b0;
  logic        reset;
  logic        store_req_valid;
  logic [31:0] store_req_addr;
  logic [31:0] store_req_data;
  logic [3:0]  store_req_byte_mask;
  logic        store_req_accepted;
  logic        dcache_wr_valid;
  logic [31:0] dcache_wr_addr;
  logic [31:0] dcache_wr_data;
  logic [3:0]  dcache_wr_byte_mask;
  logic        dcache_wr_ready;
  logic [31:0] sb_load_addr;
  logic [31:0] sb_load_data;
  logic [3:0]  sb_load_mask;
  logic [2:0]  sb_count;
  logic        sb_empty;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] exp_addr [4];

  store_commit_buffer dut (
    .clock               (clock),
    .reset               (reset),
    .store_req_valid     (store_req_valid),
    .store_req_addr      (store_req_addr),
    .store_req_data      (store_req_data),
    .store_req_byte_mask (store_req_byte_mask),
    .store_req_accepted  (store_req_accepted),
    .dcache_wr_valid     (dcache_wr_valid),
    .dcache_wr_addr      (dcache_wr_addr),
    .dcache_wr_data      (dcache_wr_data),
    .dcache_wr_byte_mask (dcache_wr_byte_mask),
    .dcache_wr_ready     (dcache_wr_ready),
    .sb_load_addr        (sb_load_addr),
    .sb_load_data        (sb_load_data),
    .sb_load_mask        (sb_load_mask),
    .sb_count            (sb_count),
    .sb_empty            (sb_empty)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    store_req_valid     = v;
    store_req_addr      = a;
    store_req_data      = d;
    store_req_byte_mask = m;
  endtask

  task automatic drain_all();
    int n;
    n = 0;
    dcache_wr_ready = 1'b1;
    while (!sb_empty && n < 10) begin
      tick();
      n++;
    end
    dcache_wr_ready = 1'b0;
    #1;
    check("drain_empty", 64'(sb_empty), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset           = 1'b1;
    dcache_wr_ready = 1'b0;
    sb_load_addr    = '0;
    drive(1'b0, '0, '0, '0);
    tick();
    tick();
    check("rst_empty", 64'(sb_empty), 64'd1);
    check("rst_count", 64'(sb_count), 64'd0);
    check("rst_wr_valid", 64'(dcache_wr_valid), 64'd0);
    check("rst_load_mask", 64'(sb_load_mask), 64'd0);
    reset = 1'b0;

    // 1: single store, stall, then drain with head still forwarding
    drive(1'b1, 32'h100, 32'hAABBCCDD, 4'hF);
    #1;
    check("t1_accept", 64'(store_req_accepted), 64'd1);
    check("t1_not_visible", 64'(dcache_wr_valid), 64'd0);
    tick();
    drive(1'b0, '0, '0, '0);
    #1;
    check("t1_wr_valid", 64'(dcache_wr_valid), 64'd1);
    check("t1_wr_addr", 64'(dcache_wr_addr), 64'h100);
    check("t1_wr_data", 64'(dcache_wr_data), 64'hAABBCCDD);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t1_stall_data", 64'(dcache_wr_data), 64'hAABBCCDD);
      check("t1_stall_valid", 64'(dcache_wr_valid), 64'd1);
    end
    dcache_wr_ready = 1'b1;
    sb_load_addr    = 32'h100;
    #1;
    check("t1_head_fwd_mask", 64'(sb_load_mask), 64'hF);
    check("t1_head_fwd_data", 64'(sb_load_data), 64'hAABBCCDD);
    tick();
    dcache_wr_ready = 1'b0;
    #1;
    check("t1_empty", 64'(sb_empty), 64'd1);
    check("t1_fwd_gone", 64'(sb_load_mask), 64'd0);

    // 2: fill, blocked 5th store, ready does not unblock same cycle
    for (int k = 0; k < 4; k++) begin
      exp_addr[k] = 32'h210 + 32'(4 * k);
      drive(1'b1, exp_addr[k], 32'h1000 + 32'(k), 4'hF);
      tick();
    end
    drive(1'b1, 32'h200, 32'h55, 4'hF);
    #1;
    check("t2_count_full", 64'(sb_count), 64'd4);
    check("t2_full_reject", 64'(store_req_accepted), 64'd0);
    dcache_wr_ready = 1'b1;
    #1;
    check("t2_no_ready_path", 64'(store_req_accepted), 64'd0);
    check("t2_head_addr", 64'(dcache_wr_addr), 64'(exp_addr[0]));
    tick();
    dcache_wr_ready = 1'b0;
    #1;
    check("t2_count_after_pop", 64'(sb_count), 64'd3);
    check("t2_accept_next", 64'(store_req_accepted), 64'd1);
    tick();
    drive(1'b0, '0, '0, '0);
    #1;
    check("t2_count_refill", 64'(sb_count), 64'd4);
    dcache_wr_ready = 1'b1;
    #1;
    for (int k = 1; k < 4; k++) begin
      check("t2_order_addr", 64'(dcache_wr_addr), 64'(exp_addr[k]));
      check("t2_order_data", 64'(dcache_wr_data), 64'h1000 + 64'(k));
      tick();
    end
    check("t2_order_last", 64'(dcache_wr_addr), 64'h200);
    tick();
    dcache_wr_ready = 1'b0;
    #1;
    check("t2_empty", 64'(sb_empty), 64'd1);

    // 3: byte-granular forwarding across entries, youngest wins
    drive(1'b1, 32'h300, 32'h00001122, 4'b0011);
    tick();
    drive(1'b1, 32'h300, 32'h00330000, 4'b0100);
    tick();
    drive(1'b0, '0, '0, '0);
    sb_load_addr = 32'h300;
    #1;
    check("t3_count", 64'(sb_count), 64'd2);
    check("t3_fwd_data", 64'(sb_load_data), 64'h00331122);
    check("t3_fwd_mask", 64'(sb_load_mask), 64'h7);
    drive(1'b1, 32'h300, 32'h000000EE, 4'b0001);
    #1;
    check("t3_not_yet_visible", 64'(sb_load_data), 64'h00331122);
    tick();
    drive(1'b0, '0, '0, '0);
    #1;
    check("t3_young_data", 64'(sb_load_data), 64'h003311EE);
    check("t3_young_mask", 64'(sb_load_mask), 64'h7);
`ifdef STORE_COALESCE_EN
    check("t3_count_merged", 64'(sb_count), 64'd2);
`else
    check("t3_count_new", 64'(sb_count), 64'd3);
`endif
    sb_load_addr = 32'h304;
    #1;
    check("t3_other_word", 64'(sb_load_mask), 64'd0);
    drain_all();

    // 4: coalescing (or its absence)
`ifdef STORE_COALESCE_EN
    drive(1'b1, 32'h400, 32'h44444444, 4'hF);
    tick();
    drive(1'b1, 32'h400, 32'h00000900, 4'b0010);
    #1;
    check("t4_head_no_merge_acc", 64'(store_req_accepted), 64'd1);
    tick();
    drive(1'b0, '0, '0, '0);
    #1;
    check("t4_head_no_merge_cnt", 64'(sb_count), 64'd2);
    drive(1'b1, 32'h500, 32'h00000011, 4'b0001);
    tick();
    drive(1'b1, 32'h500, 32'h22000000, 4'b1000);
    tick();
    drive(1'b0, '0, '0, '0);
    sb_load_addr = 32'h500;
    #1;
    check("t4_count", 64'(sb_count), 64'd3);
    check("t4_fwd_mask", 64'(sb_load_mask), 64'h9);
    check("t4_fwd_data", 64'(sb_load_data), 64'h22000011);
    dcache_wr_ready = 1'b1;
    tick();
    tick();
    dcache_wr_ready = 1'b0;
    #1;
    check("t4_entry_mask", 64'(dcache_wr_byte_mask), 64'h9);
    check("t4_entry_data", 64'(dcache_wr_data), 64'h22000011);
`else
    drive(1'b1, 32'h500, 32'h00000011, 4'b0001);
    tick();
    drive(1'b1, 32'h500, 32'h22000000, 4'b1000);
    tick();
    drive(1'b0, '0, '0, '0);
    sb_load_addr = 32'h500;
    #1;
    check("t4_count", 64'(sb_count), 64'd2);
    check("t4_fwd_mask", 64'(sb_load_mask), 64'h9);
    check("t4_fwd_data", 64'(sb_load_data), 64'h22000011);
    check("t4_head_mask", 64'(dcache_wr_byte_mask), 64'h1);
`endif
    drain_all();

    // 5: continuous push/pop, pointers wrap several times
    dcache_wr_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 32'h600 + 32'(4 * k), 32'hC0DE0000 + 32'(k), 4'hF);
      #1;
      check("t5_accept", 64'(store_req_accepted), 64'd1);
      check("t5_count", 64'(sb_count), (k == 0) ? 64'd0 : 64'd1);
      if (k > 0) begin
        check("t5_drain_addr", 64'(dcache_wr_addr), 64'h600 + 64'(4 * (k - 1)));
        check("t5_drain_data", 64'(dcache_wr_data), 64'hC0DE0000 + 64'(k - 1));
      end
      tick();
    end
    drive(1'b0, '0, '0, '0);
    #1;
    check("t5_last_addr", 64'(dcache_wr_addr), 64'h624);
    tick();
    dcache_wr_ready = 1'b0;
    #1;
    check("t5_empty", 64'(sb_empty), 64'd1);

    // 6: reset while holding entries
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h700 + 32'(4 * k), 32'h77000000 + 32'(k), 4'hF);
      tick();
    end
    drive(1'b0, '0, '0, '0);
    sb_load_addr = 32'h704;
    #1;
    check("t6_count_pre", 64'(sb_count), 64'd3);
    check("t6_fwd_pre", 64'(sb_load_data), 64'h77000001);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("t6_count", 64'(sb_count), 64'd0);
    check("t6_wr_valid", 64'(dcache_wr_valid), 64'd0);
    check("t6_load_mask", 64'(sb_load_mask), 64'd0);
    check("t6_wr_addr", 64'(dcache_wr_addr), 64'd0);
    check("t6_empty", 64'(sb_empty), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/store_commit_buffer.md
Name: store_commit_buffer

Overview:
- Post-retirement store buffer. It sits between the store queue's committed-store port (store_req_*) and the D-cache write port.
- Accepts retired stores one per cycle, optionally coalesces consecutive stores to the same word, and drains them in order to the D-cache under a valid/ready handshake.
- Once a store leaves the store queue, the queue no longer forwards it to loads. This block therefore provides byte-granular load forwarding for everything it holds, so loads never miss committed-but-unwritten data.

Parameters:
- SB_DEPTH, 4, number of buffer entries; must be a power of 2 and at least 2.
- SB_IDX_BITS, $clog2(SB_DEPTH), entry index width.

Ports:
- clock  input  1  system clock; everything is clocked on the posedge.
- reset  input  1  synchronous, active-high reset.
- store_req_valid  input  1  the store queue has a retired store at its true head.
- store_req_addr  input  ADDR(32)  store address; only the word address (.w.addr) is used.
- store_req_data  input  DATA(32)  store data, byte-lane aligned.
- store_req_byte_mask  input  BYTE_MASK(4)  byte lanes written.
- store_req_accepted  output  1  the store is taken this cycle; the store queue advances its true head.
- dcache_wr_valid  output  1  the head entry is presented to the D-cache.
- dcache_wr_addr  output  ADDR(32)  head word address; byte offset is zero.
- dcache_wr_data  output  DATA(32)  head data.
- dcache_wr_byte_mask  output  BYTE_MASK(4)  head byte mask.
- dcache_wr_ready  input  1  the D-cache accepts the head this cycle.
- sb_load_addr  input  ADDR(32)  load lookup address.
- sb_load_data  output  DATA(32)  forwarded bytes; zero in lanes that do not hit.
- sb_load_mask  output  BYTE_MASK(4)  lanes supplied by this buffer.
- sb_count  output  SB_IDX_BITS+1  occupied entries.
- sb_empty  output  1  sb_count == 0.

Behaviour:
- State:
  - Entry array {word_addr, data, byte_mask}.
  - head and tail pointers, each SB_IDX_BITS+1 wide with a parity MSB.
  - count is derived as tail - head, computed at SB_IDX_BITS+1 width.
  - Full means the indices are equal and the parities differ. Empty means head == tail.
- Reset: head, tail and entries all go to 0. All outputs read 0 except sb_empty, which reads 1.
- Accept (push):
  - store_req_accepted = store_req_valid && (!full || coalesce_hit).
  - It depends only on registered state and the store_req_* inputs. There is no path from dcache_wr_ready.
  - A pop in the same cycle does not free space for a push that cycle. A full buffer therefore takes a non-coalescing store 1 cycle after the pop.
- Drain (pop):
  - dcache_wr_valid = !empty; the head entry drives dcache_wr_*.
  - Pop happens when dcache_wr_valid && dcache_wr_ready; head increments in that case.
  - The head entry's addr, data and mask are stable while valid && !ready. No entry is ever modified while it is head.
- Simultaneous push and pop: tail and head both increment, so count is unchanged.
- Wrap-around: pointers roll modulo 2*SB_DEPTH, and the parity bit disambiguates full from empty.
- Load forwarding (combinational, same cycle):
  - For each byte lane b, select the youngest valid entry with matching word address and byte_mask[b] set.
  - That entry supplies sb_load_data.bytes[b], and sb_load_mask[b] = 1.
  - The head being drained this cycle still forwards, because it is valid until the clock edge.
  - A store accepted this cycle is not visible to loads until the next cycle.
- Latency: a store accepted at cycle t presents on dcache_wr_* no earlier than t+1.
- Ordering: stores drain to the D-cache in strict program order.

Optional Feature:
- Macro: STORE_COALESCE_EN.
- Defined:
  - coalesce_hit = store_req_valid && !empty && entry[tail-1].word_addr == store_req_addr.w.addr && (tail-1) != head.
  - On a hit, merge new bytes over old per lane and OR the masks; tail does not move.
  - Accepted even when the buffer is full.
- Undefined: coalesce_hit = 0, and every store takes a new entry.

Decomposition:
- SB_DEPTH default, SB_ENTRY typedef {ADDR word_addr; DATA data; BYTE_MASK byte_mask}, and the SB_POINTER typedef go in sys_defs.svh next to the SQ types.
- One sub-module, sb_forward_sel: per-lane youngest-match selector. It rotates the match vector by head index, feeds it to psel_gen, and un-rotates the grant.

Test Plan:
1. Reset, then push store addr 0x100 data 0xAABBCCDD mask 4'b1111 with ready=0 → accepted=1; next cycle dcache_wr_valid=1, addr 0x100, data 0xAABBCCDD. Hold ready=0 for 3 cycles → outputs stable; ready=1 → sb_empty=1 next cycle.
2. Push 4 stores to distinct words with ready=0 → sb_count=4; 5th store to 0x200 → store_req_accepted=0. Assert ready for 1 cycle → 5th accepted the following cycle, and drain order matches push order.
3. Entries: 0x300 mask 4'b0011 data 0x00001122, then 0x300 mask 4'b0100 data 0x00330000 (coalesce off). Load 0x300 → sb_load_data=0x00331122, sb_load_mask=4'b0111.
4. STORE_COALESCE_EN: head 0x400, then two stores to 0x500 with masks 4'b0001 and 4'b1000 → sb_count=2, entry mask 4'b1001. A store to 0x400 while 0x400 is head and the only entry → new entry, sb_count increments.
5. Wrap-around: 10 push/pop pairs with ready=1 continuously → no drop or duplicate, sb_count ≤ 1, and pointer parity toggles correctly.
6. Reset asserted with 3 entries held and ready=0 → next cycle sb_count=0, dcache_wr_valid=0, sb_load_mask=0.
